// File: rtl/rr_mux_arbiter_if.sv
// Requester/downstream bundle for the round-robin mux arbiter.
// The master modport is the requester+downstream side, slave is the arbiter.
interface rr_mux_arbiter_if #(
    parameter int unsigned DATA_W = 4
);
    logic [3:0]        req;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out;
    logic [1:0]        sel;
    logic [3:0]        grant;
    logic [3:0]        ack;
    logic              busy;

    modport master (
        output req, a, b, c, d, out_ready,
        input  out_valid, out, sel, grant, ack, busy
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output out_valid, out, sel, grant, ack, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters with burst-length grants and a
// valid/ready output; each release inserts one IDLE bubble before the next grant.
module rr_mux_arbiter #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned BURST_LEN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_mux_arbiter_if.slave bus
);
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                 out_valid_c;
    logic                 transfer_c;
    logic [SEL_W-1:0]     pick_c;
    logic [DATA_W-1:0]    word_c;

    // First set request bit searching from the pointer upward, wrapping mod 4.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = p + SEL_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Output datapath and handshake.
    always_comb begin
        pick_c      = rr_pick(bus.req, ptr_q);
        out_valid_c = (state_q == S_GRANT) && bus.req[sel_q];
        transfer_c  = out_valid_c && bus.out_ready;
        case (sel_q)
            2'd0:    word_c = bus.a;
            2'd1:    word_c = bus.b;
            2'd2:    word_c = bus.c;
            default: word_c = bus.d;
        endcase
        bus.out_valid = out_valid_c;
        bus.out       = out_valid_c ? word_c : '0;
        bus.ack       = transfer_c ? grant_q : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req != '0) begin
                    sel_d      = pick_c;
                    grant_d    = NUM_REQ'(1) << pick_c;
                    beat_cnt_d = '0;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!out_valid_c) begin
                    // Granted requester withdrew: release without a handshake.
                    ptr_d   = sel_q + SEL_W'(1);
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (transfer_c) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        ptr_d      = sel_q + SEL_W'(1);
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == S_GRANT);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter at BURST_LEN 1, 3 and 4.
module tb_rr_mux_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_mux_arbiter_if #(.DATA_W(4)) bus1 ();
    rr_mux_arbiter_if #(.DATA_W(4)) bus3 ();
    rr_mux_arbiter_if #(.DATA_W(4)) bus4 ();

    rr_mux_arbiter #(.DATA_W(4), .BURST_LEN(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    rr_mux_arbiter #(.DATA_W(4), .BURST_LEN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    rr_mux_arbiter #(.DATA_W(4), .BURST_LEN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus1.req = '0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.d = '0; bus1.out_ready = 1'b0;
        bus3.req = '0; bus3.a = '0; bus3.b = '0; bus3.c = '0; bus3.d = '0; bus3.out_ready = 1'b0;
        bus4.req = '0; bus4.a = '0; bus4.b = '0; bus4.c = '0; bus4.d = '0; bus4.out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.grant !== 4'b0000 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got grant=%b busy=%b exp grant=0000 busy=0", bus1.grant, bus1.busy);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus1.grant !== 4'b0000 || bus1.sel !== 2'b00 || bus1.out_valid !== 1'b0 ||
                bus1.out !== 4'h0 || bus1.ack !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got grant=%b sel=%b valid=%b out=%h ack=%b exp 0000/00/0/0/0000",
                         i, bus1.grant, bus1.sel, bus1.out_valid, bus1.out, bus1.ack);
            end
        end
    endtask

    task automatic test_single();
        bus1.req = 4'b0100; bus1.c = 4'hA; bus1.out_ready = 1'b1;
        step();
        #1;
        checks++;
        if (bus1.grant !== 4'b0100 || bus1.sel !== 2'b10 || bus1.out !== 4'hA ||
            bus1.ack !== 4'b0100 || bus1.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got grant=%b sel=%b out=%h ack=%b busy=%b exp 0100/10/a/0100/1",
                     bus1.grant, bus1.sel, bus1.out, bus1.ack, bus1.busy);
        end
        step();
        #1;
        checks++;
        if (bus1.grant !== 4'b0000 || bus1.ack !== 4'b0000 || bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_bubble got grant=%b ack=%b valid=%b busy=%b exp 0000/0000/0/0",
                     bus1.grant, bus1.ack, bus1.out_valid, bus1.busy);
        end
        step();
        checks++;
        if (bus1.grant !== 4'b0100 || bus1.sel !== 2'b10) begin
            failures++;
            $display("FAIL single_regrant got grant=%b sel=%b exp 0100/10", bus1.grant, bus1.sel);
        end
        bus1.req = 4'b0000;
        #1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.out !== 4'h0 || bus1.ack !== 4'b0000) begin
            failures++;
            $display("FAIL single_drop got valid=%b out=%h ack=%b exp 0/0/0000", bus1.out_valid, bus1.out, bus1.ack);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        pulse_reset();
        bus1.req = 4'b1111; bus1.out_ready = 1'b1;
        bus1.a = 4'h1; bus1.b = 4'h2; bus1.c = 4'h3; bus1.d = 4'h4;
        for (int k = 0; k < 5; k++) begin
            exp_s = 2'(k % 4);
            exp_g = 4'(1 << (k % 4));
            step();
            #1;
            checks++;
            if (bus1.grant !== exp_g || bus1.sel !== exp_s || bus1.out !== 4'(k % 4 + 1) || bus1.ack !== exp_g) begin
                failures++;
                $display("FAIL rr_grant k=%0d got grant=%b sel=%b out=%h ack=%b exp %b/%b/%h/%b",
                         k, bus1.grant, bus1.sel, bus1.out, bus1.ack, exp_g, exp_s, 4'(k % 4 + 1), exp_g);
            end
            step();
            checks++;
            if (bus1.grant !== 4'b0000 || bus1.busy !== 1'b0) begin
                failures++;
                $display("FAIL rr_bubble k=%0d got grant=%b busy=%b exp 0000/0", k, bus1.grant, bus1.busy);
            end
        end
        bus1.req = 4'b0000;
        step();
    endtask

    task automatic test_burst_stall();
        logic [4:0] pat;
        int         acks;
        pat  = 5'b11001;
        acks = 0;
        bus3.req = 4'b0010; bus3.b = 4'h5; bus3.out_ready = 1'b0;
        step();
        for (int j = 0; j < 5; j++) begin
            bus3.out_ready = pat[j];
            #1;
            checks++;
            if (bus3.grant !== 4'b0010 || bus3.sel !== 2'b01 || bus3.out !== 4'h5 ||
                bus3.ack !== (pat[j] ? 4'b0010 : 4'b0000)) begin
                failures++;
                $display("FAIL burst_beat j=%0d got grant=%b sel=%b out=%h ack=%b exp 0010/01/5/%b",
                         j, bus3.grant, bus3.sel, bus3.out, bus3.ack, pat[j] ? 4'b0010 : 4'b0000);
            end
            if (bus3.ack == 4'b0010) acks++;
            step();
        end
        checks++;
        if (acks != 3 || bus3.grant !== 4'b0000 || bus3.busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_release got acks=%0d grant=%b busy=%b exp 3/0000/0", acks, bus3.grant, bus3.busy);
        end
        bus3.req = 4'b0110; bus3.out_ready = 1'b0;
        step();
        checks++;
        if (bus3.grant !== 4'b0100 || bus3.sel !== 2'b10) begin
            failures++;
            $display("FAIL burst_next_ptr got grant=%b sel=%b exp 0100/10", bus3.grant, bus3.sel);
        end
        bus3.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_withdrawal();
        bus1.req = 4'b1000; bus1.d = 4'hC; bus1.a = 4'h3; bus1.out_ready = 1'b0;
        step();
        #1;
        checks++;
        if (bus1.grant !== 4'b1000 || bus1.sel !== 2'b11 || bus1.out_valid !== 1'b1 || bus1.out !== 4'hC) begin
            failures++;
            $display("FAIL wd_grant got grant=%b sel=%b valid=%b out=%h exp 1000/11/1/c",
                     bus1.grant, bus1.sel, bus1.out_valid, bus1.out);
        end
        bus1.req = 4'b0001;
        #1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.ack !== 4'b0000 || bus1.out !== 4'h0) begin
            failures++;
            $display("FAIL wd_drop got valid=%b ack=%b out=%h exp 0/0000/0", bus1.out_valid, bus1.ack, bus1.out);
        end
        step();
        checks++;
        if (bus1.grant !== 4'b0000 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle got grant=%b busy=%b exp 0000/0", bus1.grant, bus1.busy);
        end
        bus1.req = 4'b1001;
        step();
        checks++;
        if (bus1.grant !== 4'b0001 || bus1.sel !== 2'b00) begin
            failures++;
            $display("FAIL wd_wrap got grant=%b sel=%b exp 0001/00", bus1.grant, bus1.sel);
        end
        bus1.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        int acks;
        acks = 0;
        bus4.req = 4'b0001; bus4.a = 4'h7; bus4.out_ready = 1'b1;
        step();
        for (int j = 0; j < 2; j++) begin
            #1;
            if (bus4.ack == 4'b0001) acks++;
            step();
        end
        checks++;
        if (acks != 2 || bus4.grant !== 4'b0001) begin
            failures++;
            $display("FAIL rmb_pre got acks=%0d grant=%b exp 2/0001", acks, bus4.grant);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.grant !== 4'b0000 || bus4.out_valid !== 1'b0 || bus4.ack !== 4'b0000 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL rmb_async got grant=%b valid=%b ack=%b busy=%b exp 0000/0/0000/0",
                     bus4.grant, bus4.out_valid, bus4.ack, bus4.busy);
        end
        bus4.req = 4'b1111; bus4.b = 4'h8;
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus4.grant !== 4'b0001 || bus4.sel !== 2'b00) begin
            failures++;
            $display("FAIL rmb_first got grant=%b sel=%b exp 0001/00", bus4.grant, bus4.sel);
        end
        // A full fresh burst of four beats is owed after reset.
        step();
        step();
        step();
        checks++;
        if (bus4.grant !== 4'b0001) begin
            failures++;
            $display("FAIL rmb_beat4 got grant=%b exp 0001", bus4.grant);
        end
        step();
        checks++;
        if (bus4.grant !== 4'b0000) begin
            failures++;
            $display("FAIL rmb_release got grant=%b exp 0000", bus4.grant);
        end
        step();
        checks++;
        if (bus4.grant !== 4'b0010) begin
            failures++;
            $display("FAIL rmb_rotate got grant=%b exp 0010", bus4.grant);
        end
        bus4.req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_stall();
        test_withdrawal();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
